// File: rtl/bsg_circular_ptr_rd_tracker_pkg.sv
// Shared types and width helpers for the circular read-pointer tracker.
package bsg_circular_ptr_rd_tracker_pkg;

    typedef enum logic [1:0] {
        e_ok,
        e_underflow,
        e_overflow
    } err_cause_e;

    // Pointer width that never collapses to zero bits for a single-slot buffer.
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    function automatic int cnt_width(input int slots);
        return $clog2(slots + 1);
    endfunction

endpackage

// File: rtl/bsg_circular_ptr_rd_tracker_if.sv
// Add/sub request and pointer/flag status bundle for the read tracker.
interface bsg_circular_ptr_rd_tracker_if
    import bsg_circular_ptr_rd_tracker_pkg::*;
#(
    parameter int slots_p   = 5,
    parameter int max_add_p = 2,
    parameter int max_sub_p = 2
);
    localparam int ptr_width_lp = safe_clog2(slots_p);
    localparam int cnt_width_lp = cnt_width(slots_p);
    localparam int add_width_lp = $clog2(max_add_p + 1);
    localparam int sub_width_lp = $clog2(max_sub_p + 1);

    logic [add_width_lp-1:0] add_i;
    logic [sub_width_lp-1:0] sub_i;
    logic [ptr_width_lp-1:0] wr_ptr_o;
    logic [ptr_width_lp-1:0] rd_ptr_o;
    logic [ptr_width_lp-1:0] rd_ptr_n_o;
    logic [cnt_width_lp-1:0] count_o;
    logic [sub_width_lp-1:0] avail_o;
    logic                    empty_o;
    logic                    full_o;
    logic                    err_o;

    modport master (
        output add_i, sub_i,
        input  wr_ptr_o, rd_ptr_o, rd_ptr_n_o, count_o, avail_o, empty_o, full_o, err_o
    );

    modport slave (
        input  add_i, sub_i,
        output wr_ptr_o, rd_ptr_o, rd_ptr_n_o, count_o, avail_o, empty_o, full_o, err_o
    );

endinterface

// File: rtl/bsg_circular_ptr_arst.sv
// Circular pointer modulo slots_p with async active-low reset; n_o is the
// value the pointer takes at the next edge.
module bsg_circular_ptr_arst
    import bsg_circular_ptr_rd_tracker_pkg::*;
#(
    parameter  int slots_p      = 5,
    parameter  int max_add_p    = 2,
    localparam int ptr_width_lp = safe_clog2(slots_p),
    localparam int add_width_lp = $clog2(max_add_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [add_width_lp-1:0] add_i,
    output logic [ptr_width_lp-1:0] o,
    output logic [ptr_width_lp-1:0] n_o
);

    if (slots_p == 1) begin : g_single
        logic unused;
        assign unused = ^{add_i, clk_i, reset_n_i};
        assign o      = '0;
        assign n_o    = '0;
    end else begin : g_multi
        logic [ptr_width_lp-1:0] ptr_r;

        if ((slots_p & (slots_p - 1)) == 0) begin : g_pow2
            assign n_o = ptr_r + ptr_width_lp'(add_i);
        end else begin : g_npow2
            // ptr + n and ptr + n - slots in parallel; the sign bit of the
            // difference picks the wrapped or unwrapped result.
            logic [ptr_width_lp:0] sum;
            logic [ptr_width_lp:0] diff;
            assign sum  = {1'b0, ptr_r} + (ptr_width_lp + 1)'(add_i);
            assign diff = sum - (ptr_width_lp + 1)'(slots_p);
            assign n_o  = diff[ptr_width_lp] ? sum[ptr_width_lp-1:0]
                                             : diff[ptr_width_lp-1:0];
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) ptr_r <= '0;
            else            ptr_r <= n_o;
        end

        assign o = ptr_r;
    end

endmodule

// File: rtl/bsg_circular_ptr_rd_tracker.sv
// Read/write pointer and occupancy tracker for a multi-enqueue/dequeue
// circular buffer. Define BSG_CIRCULAR_PTR_RD_TRACKER_CHECK_EN for checking.
module bsg_circular_ptr_rd_tracker
    import bsg_circular_ptr_rd_tracker_pkg::*;
#(
    parameter  int slots_p      = 5,
    parameter  int max_add_p    = 2,
    parameter  int max_sub_p    = 2,
    localparam int ptr_width_lp = safe_clog2(slots_p),
    localparam int cnt_width_lp = cnt_width(slots_p),
    localparam int add_width_lp = $clog2(max_add_p + 1),
    localparam int sub_width_lp = $clog2(max_sub_p + 1)
) (
    input logic                         clk_i,
    input logic                         reset_n_i,
    bsg_circular_ptr_rd_tracker_if.slave trk
);

    logic [add_width_lp-1:0] add_eff;
    logic [sub_width_lp-1:0] sub_eff;
    logic [cnt_width_lp-1:0] count_r;
    logic [cnt_width_lp-1:0] count_n;

`ifdef BSG_CIRCULAR_PTR_RD_TRACKER_CHECK_EN
    // One extra bit so count + add cannot wrap before the overflow compare.
    localparam int chk_width_lp = cnt_width_lp + 1;

    logic       underflow;
    logic       overflow;
    logic       illegal;
    logic       err_r;
    err_cause_e cause;

    always_comb begin
        underflow = chk_width_lp'(trk.sub_i) > chk_width_lp'(count_r);
        overflow  = (chk_width_lp'(count_r) + chk_width_lp'(trk.add_i))
                  > (chk_width_lp'(slots_p) + chk_width_lp'(trk.sub_i));
        illegal   = underflow | overflow;
        add_eff   = illegal ? '0 : trk.add_i;
        sub_eff   = illegal ? '0 : trk.sub_i;
        cause     = underflow ? e_underflow : (overflow ? e_overflow : e_ok);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) err_r <= 1'b0;
        else            err_r <= err_r | illegal;
    end

    assign trk.err_o = err_r;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i && illegal)
            $error("bsg_circular_ptr_rd_tracker: %s count=%0d add=%0d sub=%0d",
                   cause.name(), count_r, trk.add_i, trk.sub_i);
    end
`endif
`else
    assign add_eff   = trk.add_i;
    assign sub_eff   = trk.sub_i;
    assign trk.err_o = 1'b0;
`endif

    bsg_circular_ptr_arst #(
        .slots_p   (slots_p),
        .max_add_p (max_add_p)
    ) wr_ptr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .add_i     (add_eff),
        .o         (trk.wr_ptr_o),
        .n_o       ()
    );

    bsg_circular_ptr_arst #(
        .slots_p   (slots_p),
        .max_add_p (max_sub_p)
    ) rd_ptr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .add_i     (sub_eff),
        .o         (trk.rd_ptr_o),
        .n_o       (trk.rd_ptr_n_o)
    );

    assign count_n = count_r + cnt_width_lp'(add_eff) - cnt_width_lp'(sub_eff);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) count_r <= '0;
        else            count_r <= count_n;
    end

    // Flags decode the registered count only: no same-cycle write bypass.
    assign trk.count_o = count_r;
    assign trk.empty_o = (count_r == '0);
    assign trk.full_o  = (count_r == cnt_width_lp'(slots_p));
    assign trk.avail_o = (count_r > cnt_width_lp'(max_sub_p)) ? sub_width_lp'(max_sub_p)
                                                               : sub_width_lp'(count_r);

endmodule

// File: tb/tb_bsg_circular_ptr_rd_tracker.sv
// Scoreboard bench for bsg_circular_ptr_rd_tracker (slots 5, add/sub up to 2).
module tb_bsg_circular_ptr_rd_tracker;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bsg_circular_ptr_rd_tracker_if #(.slots_p(5), .max_add_p(2), .max_sub_p(2)) trk ();

    bsg_circular_ptr_rd_tracker #(.slots_p(5), .max_add_p(2), .max_sub_p(2)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .trk       (trk)
    );

    typedef struct {
        string name;
        int    wr, rd, rdn, cnt, avail, empty, full, err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: every falling edge, compare the oldest pending expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (int'(trk.wr_ptr_o) != e.wr || int'(trk.rd_ptr_o) != e.rd ||
                int'(trk.rd_ptr_n_o) != e.rdn || int'(trk.count_o) != e.cnt ||
                int'(trk.avail_o) != e.avail || int'(trk.empty_o) != e.empty ||
                int'(trk.full_o) != e.full || int'(trk.err_o) != e.err) begin
                errors++;
                $display("FAIL %s: got wr=%0d rd=%0d rdn=%0d cnt=%0d av=%0d e=%0d f=%0d err=%0d, exp wr=%0d rd=%0d rdn=%0d cnt=%0d av=%0d e=%0d f=%0d err=%0d",
                         e.name, trk.wr_ptr_o, trk.rd_ptr_o, trk.rd_ptr_n_o, trk.count_o,
                         trk.avail_o, trk.empty_o, trk.full_o, trk.err_o,
                         e.wr, e.rd, e.rdn, e.cnt, e.avail, e.empty, e.full, e.err);
            end
        end
    end

    task automatic expect_state(input string name, input int wr, input int rd, input int rdn,
                                input int cnt, input int avail, input int err);
        exp_t e;
        e.name  = name;
        e.wr    = wr;
        e.rd    = rd;
        e.rdn   = rdn;
        e.cnt   = cnt;
        e.avail = avail;
        e.empty = (cnt == 0) ? 1 : 0;
        e.full  = (cnt == 5) ? 1 : 0;
        e.err   = err;
        q.push_back(e);
    endtask

    // After the next rising edge, drive add/sub and queue the expected view:
    // registered state from that edge plus rd_ptr_n for the new sub.
    task automatic step(input string name, input int add, input int sub, input int wr,
                        input int rd, input int rdn, input int cnt, input int avail,
                        input int err);
        @(posedge clk);
        #1;
        trk.add_i = 2'(add);
        trk.sub_i = 2'(sub);
        expect_state(name, wr, rd, rdn, cnt, avail, err);
    endtask

    initial begin
        trk.add_i = '0;
        trk.sub_i = '0;
        #22 rst_n = 1'b1;

        //    name          add sub wr rd rdn cnt av err
        step("idle0",        0, 0,  0, 0, 0,  0,  0, 0);
        step("idle1",        0, 0,  0, 0, 0,  0,  0, 0);
        step("idle2",        0, 0,  0, 0, 0,  0,  0, 0);
        step("fill_a2",      2, 0,  0, 0, 0,  0,  0, 0);
        step("fill_a2b",     2, 0,  2, 0, 0,  2,  2, 0);
        step("fill_a1",      1, 0,  4, 0, 0,  4,  2, 0);
        step("full_both",    2, 2,  0, 0, 2,  5,  2, 0);
        step("drain_s2",     0, 2,  2, 2, 4,  5,  2, 0);
        step("drain_s2b",    0, 2,  2, 4, 1,  3,  2, 0);
        step("drain_s1",     0, 1,  2, 1, 2,  1,  1, 0);
        step("drained",      0, 0,  2, 2, 2,  0,  0, 0);
        step("refill_a2",    2, 0,  2, 2, 2,  0,  0, 0);
        step("refill_a1s1",  1, 1,  4, 2, 3,  2,  2, 0);
        step("refill_a1",    1, 0,  0, 3, 3,  2,  2, 0);
        step("cnt3_idle",    0, 0,  1, 3, 3,  3,  2, 0);

        // Asynchronous reset mid-cycle with count 3; checked before next edge.
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 expect_state("async_rst", 0, 0, 0, 0, 0, 0);
        step("rst_hold",     2, 0,  0, 0, 0,  0,  0, 0);
        @(negedge clk);
        #1;
        trk.add_i = '0;
        rst_n     = 1'b1;

`ifdef BSG_CIRCULAR_PTR_RD_TRACKER_CHECK_EN
        step("underflow",    0, 1,  0, 0, 0,  0,  0, 0);
        step("err_set",      0, 0,  0, 0, 0,  0,  0, 1);
        step("err_sticky",   1, 0,  0, 0, 0,  0,  0, 1);
        step("err_legal",    0, 0,  1, 0, 0,  1,  1, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 expect_state("err_clear", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
`else
        step("noerr_a1",     1, 0,  0, 0, 0,  0,  0, 0);
        step("noerr_idle",   0, 0,  1, 0, 0,  1,  1, 0);
        step("noerr_s1",     0, 1,  1, 0, 1,  1,  1, 0);
        step("noerr_end",    0, 0,  1, 1, 1,  0,  0, 0);
`endif

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, exp 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_circular_ptr_rd_tracker.md
Name: bsg_circular_ptr_rd_tracker

Overview:
- Consumer-side companion to a producer's circular write pointer.
- Tracks the write and read pointers of a slots_p-entry circular buffer, plus occupancy.
- Lets the reader retire up to max_sub_p entries per cycle, never passing the writer.
- Sits beside the buffer RAM in multi-enqueue/multi-dequeue FIFOs; drives the RAM read address and the full/empty flags.

Parameters:
- slots_p, none (must be set), number of buffer entries; any value >= 1, not required to be a power of two.
- max_add_p, none (must be set), maximum entries the writer adds per cycle; must be <= slots_p.
- max_sub_p, none (must be set), maximum entries the reader retires per cycle; must be <= slots_p.
- ptr_width_lp, `BSG_SAFE_CLOG2(slots_p), pointer width (local).
- cnt_width_lp, $clog2(slots_p+1), occupancy width (local).

Ports:
- clk_i, in, 1: clock.
- reset_n_i, in, 1: asynchronous, active-low reset.
- add_i, in, $clog2(max_add_p+1): entries written this cycle.
- sub_i, in, $clog2(max_sub_p+1): entries retired by the reader this cycle.
- wr_ptr_o, out, ptr_width_lp: current write pointer (registered).
- rd_ptr_o, out, ptr_width_lp: current read pointer (registered); RAM read address.
- rd_ptr_n_o, out, ptr_width_lp: next-cycle read pointer (combinational), for synchronous-read RAMs.
- count_o, out, cnt_width_lp: current occupancy.
- avail_o, out, $clog2(max_sub_p+1): min(count_o, max_sub_p); the legal upper bound for sub_i.
- empty_o, out, 1: count_o == 0.
- full_o, out, 1: count_o == slots_p.
- err_o, out, 1: sticky protocol-error flag (see Optional Feature).

Behaviour:
- Reset (reset_n_i low, asynchronous): wr_ptr, rd_ptr and count go to 0; err_o goes to 0.
  - Outputs then read empty_o=1, full_o=0, avail_o=0, rd_ptr_n_o=0.
  - Reset asserted mid-operation discards all in-flight state immediately.
  - Deassertion is expected to be synchronised externally.
- Each rising edge, with a legal cycle:
  - wr_ptr <= (wr_ptr + add_i) mod slots_p.
  - rd_ptr <= (rd_ptr + sub_i) mod slots_p.
  - count <= count + add_i - sub_i.
- Wrap arithmetic: compute ptr + n - slots_p one bit wider than ptr_width_lp, in parallel with ptr + n. If the wider result is non-negative, select it; otherwise select ptr + n. This holds for power-of-two and non-power-of-two slots_p.
  - Power-of-two slots_p may use plain truncating addition.
  - slots_p == 1: both pointers are constant 0, and only count changes.
- Legal cycle: sub_i <= count (pre-edge) and add_i <= slots_p - count + sub_i.
  - An entry written in cycle t is retirable at the earliest in cycle t+1. There is no same-cycle bypass, so avail_o uses only the registered count.
  - Simultaneous add and sub is legal when full: on a full buffer, add_i == sub_i keeps count at slots_p.
  - On an empty buffer, add_i > 0 with sub_i == 0 is the only legal non-idle case.
- rd_ptr_n_o equals the value rd_ptr takes at the next edge, with zero added latency.
- full_o, empty_o and avail_o are combinational decodes of the registered count only.

Optional Feature:
- Macro: BSG_CIRCULAR_PTR_RD_TRACKER_CHECK_EN.
- Defined:
  - Each cycle is checked against the legality rules above.
  - An illegal cycle (underflow or overflow) leaves wr_ptr, rd_ptr and count unchanged.
  - The next edge sets err_o, which stays 1 until reset.
  - A simulation-only $error reports the count, add_i and sub_i.
- Undefined:
  - err_o is tied to 0 and no checking logic is built.
  - Inputs are required to be legal; state after an illegal cycle is unspecified.

Decomposition:
- Package bsg_circular_ptr_rd_tracker_pkg holds:
  - a width-helper function cnt_width(slots) = $clog2(slots+1);
  - an enum for error cause (e_ok, e_underflow, e_overflow), used by the checker message.
- One sub-module, bsg_circular_ptr_arst: a circular pointer with asynchronous active-low reset, add port and n_o output. It is instantiated twice, for write and read.
- The occupancy counter and flag decode stay in the top module.

Test Plan (slots_p=5, max_add_p=2, max_sub_p=2):
- Reset deassert, idle 3 cycles -> all pointers 0, count_o=0, empty_o=1, avail_o=0, err_o=0.
- add_i=2 for 2 cycles, then add_i=1 -> wr_ptr_o=0 (4 then wrap to 0), count_o=5, full_o=1, avail_o=2.
- From full, add_i=2 and sub_i=2 same cycle -> count_o stays 5; rd_ptr_o 0->2; wr_ptr_o 0->2.
- Drain with sub_i=2,2,1 -> rd_ptr_o sequence 2->4->1->2, rd_ptr_n_o leads by one cycle, count_o reaches 0, empty_o=1.
- Assert reset_n_i low mid-cycle while count_o=3 -> outputs return to reset values before the next clock edge.
- With CHECK_EN, on empty apply sub_i=1 -> state unchanged, err_o=1 after the edge and sticky until reset. Without CHECK_EN, err_o stays 0.
